// File: rtl/irq_request_ctrl.sv
// irq_request_ctrl
//   Interrupt front-end for the interrupt-pipeline CPU. Each raw request line
//   is synchronised, optionally debounced, and rising-edge detected. Every
//   accepted edge latches a pending request on irq[i]. The request is held
//   until the CPU signals service entry with a rising edge on irw[i]. If a new
//   edge arrives while the line is still pending, the sticky lost[i] flag is
//   set.
//
// Configuration macro:
//   IRQ_DEBOUNCE_EN - when defined, a per-line stability filter sits between
//                     the synchroniser and the edge detector. A level change is
//                     only accepted after it has been stable for
//                     DEBOUNCE_CYCLES cycles. When undefined, the filter is
//                     absent and no counters are built.
//
// Parameters:
//   N_IRQ           number of interrupt lines
//   SYNC_STAGES     flops per input synchroniser chain (>= 2)
//   DEBOUNCE_CYCLES stable cycles required by the debounce filter (>= 1)
//
// Ports:
//   clk       rising-edge system clock
//   rst       asynchronous, active-low reset
//   irq_src   raw asynchronous request levels, active high
//   irq_mask  1 = discard new edges on that line
//   irw       CPU in-service indication, one bit per line
//   lost_clr  synchronous clear of all lost flags
//   irq       registered pending requests to the CPU
//   lost      sticky flags: an edge arrived while the line was already pending
module irq_request_ctrl #(
  parameter int N_IRQ           = 3,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_IRQ-1:0] irq_src,
  input  logic [N_IRQ-1:0] irq_mask,
  input  logic [N_IRQ-1:0] irw,
  input  logic             lost_clr,
  output logic [N_IRQ-1:0] irq,
  output logic [N_IRQ-1:0] lost
);

  if (SYNC_STAGES < 2 || DEBOUNCE_CYCLES < 1) begin : g_param_check
    $error("irq_request_ctrl: SYNC_STAGES must be >= 2 and DEBOUNCE_CYCLES >= 1");
  end

  logic [N_IRQ-1:0] sync_q [SYNC_STAGES];
  logic [N_IRQ-1:0] sync_d [SYNC_STAGES];
  logic [N_IRQ-1:0] s;
  logic [N_IRQ-1:0] filt;
  logic [N_IRQ-1:0] filt_dly_q, filt_dly_d;
  logic [N_IRQ-1:0] irw_dly_q, irw_dly_d;
  logic [N_IRQ-1:0] rise, ack, new_req;
  logic [N_IRQ-1:0] irq_q, irq_d;
  logic [N_IRQ-1:0] lost_q, lost_d;

  // Synchroniser stage: irq_src -> s
  always_comb begin
    sync_d[0] = irq_src;
    for (int i = 1; i < SYNC_STAGES; i++) begin
      sync_d[i] = sync_q[i-1];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
    end else begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= sync_d[i];
    end
  end

  assign s = sync_q[SYNC_STAGES-1];

  // Filter stage: s -> filt
`ifdef IRQ_DEBOUNCE_EN
  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q [N_IRQ];
  logic [CNT_W-1:0] cnt_d [N_IRQ];
  logic [N_IRQ-1:0] filt_q, filt_d;

  // The counter measures how long s has disagreed with the accepted level;
  // any agreement restarts it, so short pulses never reach filt.
  always_comb begin
    filt_d = filt_q;
    for (int i = 0; i < N_IRQ; i++) begin
      cnt_d[i] = cnt_q[i];
      if (s[i] == filt_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CNT_LAST) begin
        filt_d[i] = s[i];
        cnt_d[i]  = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      filt_q <= '0;
      for (int i = 0; i < N_IRQ; i++) cnt_q[i] <= '0;
    end else begin
      filt_q <= filt_d;
      for (int i = 0; i < N_IRQ; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  assign filt = filt_q;
`else
  assign filt = s;
`endif

  // Edge detect / pending stage: filt, irw -> irq, lost
  // A new request coincident with an ack wins, so the line stays pending.
  // It does not count as lost, because the previous request was just serviced.
  always_comb begin
    filt_dly_d = filt;
    irw_dly_d  = irw;
    rise       = filt & ~filt_dly_q;
    ack        = irw & ~irw_dly_q;
    new_req    = rise & ~irq_mask;
    irq_d      = (irq_q & ~ack) | new_req;
    lost_d     = lost_clr ? '0 : (lost_q | (new_req & irq_q & ~ack));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      filt_dly_q <= '0;
      irw_dly_q  <= '0;
      irq_q      <= '0;
      lost_q     <= '0;
    end else begin
      filt_dly_q <= filt_dly_d;
      irw_dly_q  <= irw_dly_d;
      irq_q      <= irq_d;
      lost_q     <= lost_d;
    end
  end

  assign irq  = irq_q;
  assign lost = lost_q;

endmodule

// File: tb/tb_irq_request_ctrl.sv
// Self-checking bench for irq_request_ctrl. The reference model keeps a
// per-edge history of the sampled inputs. It derives the filtered level,
// edges and acks by looking back in that history, then applies the pending
// and lost rules.
module tb_irq_request_ctrl;
  localparam int N    = 3;
  localparam int SYNC = 2;
  localparam int DC   = 4;
`ifdef IRQ_DEBOUNCE_EN
  localparam int D = DC;
`else
  localparam int D = 0;
`endif
  localparam int LAT   = SYNC + D;
  localparam int QUIET = LAT + 2;
  localparam int HMAX  = 8192;

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] irq_src  = '0;
  logic [N-1:0] irq_mask = '0;
  logic [N-1:0] irw      = '0;
  logic         lost_clr = 1'b0;
  logic [N-1:0] irq, lost;

  int checks = 0;
  int errors = 0;

  irq_request_ctrl #(.N_IRQ(N), .SYNC_STAGES(SYNC), .DEBOUNCE_CYCLES(DC)) dut (
    .clk(clk), .rst(rst), .irq_src(irq_src), .irq_mask(irq_mask),
    .irw(irw), .lost_clr(lost_clr), .irq(irq), .lost(lost)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  logic [N-1:0] src_h  [HMAX];
  logic [N-1:0] irw_h  [HMAX];
  logic [N-1:0] filt_h [HMAX];
  int           e      = 0;
  logic [N-1:0] m_irq  = '0;
  logic [N-1:0] m_lost = '0;

  // Synchronised level seen just before edge x: the sample taken SYNC edges earlier.
  function automatic logic [N-1:0] s_before(input int x);
    if (x < SYNC) return '0;
    return src_h[x-SYNC];
  endfunction

  always @(posedge clk or negedge rst) begin : model
    logic [N-1:0] prev_f, f, sv, rse, ak, req, prev_irw;
    logic         flip;
    if (!rst) begin
      e = 0; m_irq = '0; m_lost = '0;
    end else if (e < HMAX) begin
      src_h[e] = irq_src;
      irw_h[e] = irw;
      prev_f   = (e > 0) ? filt_h[e-1] : '0;
      prev_irw = (e > 0) ? irw_h[e-1]  : '0;
`ifdef IRQ_DEBOUNCE_EN
      // Level flips once it has disagreed with the accepted level for DC edges.
      f = prev_f;
      for (int b = 0; b < N; b++) begin
        flip = 1'b1;
        for (int j = 1; j <= DC; j++) begin
          sv = s_before(e - j);
          if ((e - j) < 0 || sv[b] == prev_f[b]) flip = 1'b0;
        end
        if (flip) f[b] = ~prev_f[b];
      end
`else
      f = s_before(e);
`endif
      filt_h[e] = f;
      rse    = f & ~prev_f;
      ak     = irw & ~prev_irw;
      req    = rse & ~irq_mask;
      m_lost = lost_clr ? '0 : (m_lost | (req & m_irq & ~ak));
      m_irq  = (m_irq & ~ak) | req;
      e++;
    end
  end

  task automatic chk(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %b want %b at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    chk("model_irq", irq, m_irq);
    chk("model_lost", lost, m_lost);
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0;
    step(2);
    chk("reset_irq", irq, 3'b000);
    chk("reset_lost", lost, 3'b000);
    rst = 1'b1;
    step(2);

    // Single line request and ack
    irq_src = 3'b001;
    step(LAT);
    chk("lat_before", irq, 3'b000);
    step(1);
    chk("lat_set", irq, 3'b001);
    chk("lat_set_model", m_irq, 3'b001);
    step(3);
    chk("hold", irq, 3'b001);
    irw = 3'b001;
    step(1);
    chk("ack_clear", irq, 3'b000);
    step(2);
    chk("ack_held", irq, 3'b000);
    irw = 3'b000; irq_src = 3'b000;
    step(QUIET);

    // All lines at once, partial ack, re-pulse with irw held
    irq_src = 3'b111;
    step(LAT + 1);
    chk("all_set", irq, 3'b111);
    irw = 3'b010;
    step(1);
    chk("ack_line1", irq, 3'b101);
    irq_src = 3'b101;
    step(QUIET);
    irq_src = 3'b111;
    step(LAT + 1);
    chk("repulse_irq", irq, 3'b111);
    chk("repulse_lost", lost, 3'b000);
    irw = 3'b000;
    step(1);
    irw = 3'b111;
    step(1);
    chk("ack_all", irq, 3'b000);
    irw = 3'b000; irq_src = 3'b000;
    step(QUIET);

    // Lost detection, clear, coincident rise and ack
    irq_src = 3'b100;
    step(LAT + 1);
    chk("l2_set", irq, 3'b100);
    irq_src = 3'b000;
    step(QUIET);
    irq_src = 3'b100;
    step(LAT + 1);
    chk("lost_set", lost, 3'b100);
    chk("lost_set_model", m_lost, 3'b100);
    chk("lost_irq", irq, 3'b100);
    lost_clr = 1'b1;
    step(1);
    lost_clr = 1'b0;
    chk("lost_clr", lost, 3'b000);
    irq_src = 3'b000;
    step(QUIET);
    irq_src = 3'b100;
    step(LAT);
    irw = 3'b100;
    step(1);
    chk("coinc_irq", irq, 3'b100);
    chk("coinc_lost", lost, 3'b000);
    irw = 3'b000;
    step(1);
    irw = 3'b100;
    step(1);
    chk("coinc_ack", irq, 3'b000);
    irw = 3'b000; irq_src = 3'b000;
    step(QUIET);

    // Masking
    irq_mask = 3'b100;
    irq_src  = 3'b101;
    step(LAT + 1);
    chk("mask_irq", irq, 3'b001);
    chk("mask_lost", lost, 3'b000);
    irq_mask = 3'b001;
    step(2);
    chk("mask_pending", irq, 3'b001);
    irq_mask = 3'b000;
    irw = 3'b001;
    step(1);
    irw = 3'b000; irq_src = 3'b000;
    step(QUIET);

    // Asynchronous reset mid-operation, line held high through release
    irq_src = 3'b011;
    step(LAT + 1);
    irq_src = 3'b010;
    step(QUIET);
    irq_src = 3'b011;
    step(LAT + 1);
    chk("pre_rst_irq", irq, 3'b011);
    chk("pre_rst_lost", lost, 3'b001);
    #2 rst = 1'b0;
    #1;
    chk("async_rst_irq", irq, 3'b000);
    chk("async_rst_lost", lost, 3'b000);
    @(negedge clk); #1;
    rst = 1'b1;
    step(LAT + 1);
    chk("held_rise", irq, 3'b011);
    step(3);
    chk("held_lost", lost, 3'b000);
    irw = 3'b011;
    step(1);
    chk("held_ack", irq, 3'b000);
    irw = 3'b000; irq_src = 3'b000;
    step(QUIET);

`ifdef IRQ_DEBOUNCE_EN
    // Debounce filter
    irq_src = 3'b010;
    step(DC - 1);
    irq_src = 3'b000;
    step(QUIET + DC);
    chk("glitch", irq, 3'b000);
    irq_src = 3'b010;
    step(LAT);
    chk("deb_before", irq, 3'b000);
    step(1);
    chk("deb_set", irq, 3'b010);
    step(10 - LAT - 1);
    irq_src = 3'b000;
    irw = 3'b010;
    step(1);
    irw = 3'b000;
    step(QUIET);
`endif

    // Randomised phase
    for (int c = 0; c < 2500; c++) begin
      for (int b = 0; b < N; b++) begin
        if ($urandom_range(0, 7) == 0) irq_src[b] = ~irq_src[b];
      end
      if ($urandom_range(0, 3) == 0)  irw      = N'($urandom);
      if ($urandom_range(0, 15) == 0) irq_mask = N'($urandom);
      lost_clr = ($urandom_range(0, 9) == 0);
      if (c == 1200) begin
        #2 rst = 1'b0;
        #1;
        chk("rand_rst_irq", irq, 3'b000);
        @(negedge clk); #1;
        rst = 1'b1;
      end
      step(1);
    end

    step(2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
